// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scan_sequencer
//  Description : Round-robin scheduler sharing one 8-bit SAR ADC core among
//                NUM_CH requesting channels. Selects the input, pulses the
//                core start, waits a fixed conversion time, then returns the
//                captured result tagged with its channel over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer #(
    parameter  int NUM_CH      = 4,
    parameter  int CONV_CYCLES = 10,
    localparam int CW          = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_req,
    output logic [NUM_CH-1:0] ch_ack,
    output logic [CW-1:0]     adc_sel,
    output logic              adc_start,
    input  logic [7:0]        adc_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_data,
    output logic [CW-1:0]     res_ch,
    output logic              busy
);

    localparam int                  c_CNT_W    = $clog2(CONV_CYCLES);
    localparam logic [c_CNT_W-1:0]  c_CNT_LOAD = c_CNT_W'(CONV_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [NUM_CH-1:0]   c_ACK_ONE  = NUM_CH'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_CONVERT = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_last_ch;
    logic [CW-1:0]       w_last_ch_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [NUM_CH-1:0]   r_ch_ack;
    logic [NUM_CH-1:0]   w_ch_ack_nxt;
    logic [CW-1:0]       r_adc_sel;
    logic [CW-1:0]       w_adc_sel_nxt;
    logic                r_adc_start;
    logic                w_adc_start_nxt;
    logic                r_res_valid;
    logic                w_res_valid_nxt;
    logic [7:0]          r_res_data;
    logic [7:0]          w_res_data_nxt;
    logic [CW-1:0]       r_res_ch;
    logic [CW-1:0]       w_res_ch_nxt;
    logic                r_busy;
    logic                w_busy_nxt;

    logic                w_any_req;
    logic [CW-1:0]       w_grant;
    logic [CW-1:0]       w_scan_idx;

    // Round-robin search: first requester after the last served channel, wrapping.
    always_comb begin
        w_any_req  = 1'b0;
        w_grant    = '0;
        w_scan_idx = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_scan_idx = CW'((32'(r_last_ch) + 32'(i)) % NUM_CH);
            if (!w_any_req && ch_req[w_scan_idx]) begin
                w_any_req = 1'b1;
                w_grant   = w_scan_idx;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_last_ch_nxt   = r_last_ch;
        w_cnt_nxt       = r_cnt;
        w_ch_ack_nxt    = '0;
        w_adc_sel_nxt   = r_adc_sel;
        w_adc_start_nxt = 1'b0;
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        w_res_ch_nxt    = r_res_ch;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    // START outputs are registered, so raise them on entry.
                    w_state_nxt     = S_START;
                    w_adc_sel_nxt   = w_grant;
                    w_adc_start_nxt = 1'b1;
                    w_ch_ack_nxt    = c_ACK_ONE << w_grant;
                end
            end
            S_START: begin
                // adc_sel still holds the granted channel here.
                w_last_ch_nxt = r_adc_sel;
                w_cnt_nxt     = c_CNT_LOAD;
                w_state_nxt   = S_CONVERT;
            end
            S_CONVERT: begin
                if (r_cnt == '0) begin
                    w_res_data_nxt  = adc_data;
                    w_res_ch_nxt    = r_adc_sel;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = S_DELIVER;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            S_DELIVER: begin
                if (r_res_valid && res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers; reset discards any in-flight conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last_ch   <= CW'(NUM_CH - 1);
            r_cnt       <= '0;
            r_ch_ack    <= '0;
            r_adc_sel   <= '0;
            r_adc_start <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_ch    <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_ch   <= w_last_ch_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ch_ack    <= w_ch_ack_nxt;
            r_adc_sel   <= w_adc_sel_nxt;
            r_adc_start <= w_adc_start_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_ch    <= w_res_ch_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign ch_ack    = r_ch_ack;
    assign adc_sel   = r_adc_sel;
    assign adc_start = r_adc_start;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_ch    = r_res_ch;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_scan_sequencer
//  Description : Scoreboard bench for adc_scan_sequencer with a behavioural
//                ADC core, directed scenarios and a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_sequencer;

    localparam int NUM_CH      = 4;
    localparam int CONV_CYCLES = 10;
    localparam int CW          = 2;
    localparam int LATENCY     = CONV_CYCLES + 1;   // START cycle to first res_valid cycle
    localparam int PERIOD      = CONV_CYCLES + 3;   // back-to-back start spacing

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_req;
    logic [NUM_CH-1:0] ch_ack;
    logic [CW-1:0]     adc_sel;
    logic              adc_start;
    logic [7:0]        adc_data = 8'h00;
    logic              res_valid;
    logic              res_ready;
    logic [7:0]        res_data;
    logic [CW-1:0]     res_ch;
    logic              busy;

    adc_scan_sequencer #(.NUM_CH(NUM_CH), .CONV_CYCLES(CONV_CYCLES)) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_ack(ch_ack),
        .adc_sel(adc_sel), .adc_start(adc_start), .adc_data(adc_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ch(res_ch), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [7:0]    data;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration rule: first requester after the last served, wrapping.
    function automatic int rr_pick(input logic [NUM_CH-1:0] req, input int last);
        for (int k = 1; k <= NUM_CH; k++) begin
            if (req[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
        end
        return -1;
    endfunction

    // ADC core model: latches its analog value at the start edge, shows junk
    // until 9 edges later, then holds the converted value.
    logic [7:0] analog [NUM_CH];
    logic [7:0] core_val = 8'h00;
    int         core_cnt = 0;
    bit         seeded   = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            if (!seeded) begin
                for (int i = 0; i < NUM_CH; i++) analog[i] <= 8'($urandom);
                seeded <= 1'b1;
            end
            if (adc_start) begin
                core_val        <= analog[adc_sel];
                analog[adc_sel] <= 8'($urandom);
                core_cnt        <= 1;
                adc_data        <= 8'($urandom);
            end else if (core_cnt >= 1 && core_cnt < 9) begin
                core_cnt <= core_cnt + 1;
                adc_data <= 8'($urandom);
            end else if (core_cnt == 9) begin
                adc_data <= core_val;
                core_cnt <= 10;
            end
        end
    end

    // Monitor: predicts grants and result timing, pops the scoreboard on results.
    logic [NUM_CH-1:0] prev_req   = '0;
    logic              prev_busy  = 1'b0;
    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic              prev_start = 1'b0;
    logic [7:0]        prev_data  = '0;
    logic [CW-1:0]     prev_ch    = '0;
    logic [CW-1:0]     prev_sel   = '0;
    logic              prev_rst   = 1'b1;
    int                m_last     = NUM_CH - 1;
    int                start_cyc  = 0;
    int                g;
    logic              exp_start;
    exp_t              popped;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                m_last = NUM_CH - 1;
            end else begin
                exp_start = !prev_rst && !prev_busy && (prev_req != '0);
                check("start_timing", 32'(adc_start), 32'(exp_start));
                if (adc_start) begin
                    check("start_pulse_width", 32'(prev_start), 32'(0));
                    check("busy_in_start", 32'(busy), 32'(1));
                    g = rr_pick(prev_req, m_last);
                    if (g >= 0) begin
                        check("grant_sel", 32'(adc_sel), 32'(g));
                        check("grant_ack", 32'(ch_ack), 32'(1) << g);
                        exp_q.push_back({CW'(g), analog[g]});
                        m_last = g;
                    end
                    start_cyc = cyc;
                end else begin
                    check("ack_without_start", 32'(ch_ack), 32'(0));
                end
                if (adc_sel != prev_sel && !adc_start)
                    check("sel_stable", 32'(adc_sel), 32'(prev_sel));
                if (res_valid && !prev_valid) begin
                    check("result_latency", 32'(cyc - start_cyc), 32'(LATENCY));
                    check("result_expected", 32'(exp_q.size() != 0), 32'(1));
                    if (exp_q.size() != 0) begin
                        popped = exp_q.pop_front();
                        check("res_data", 32'(res_data), 32'(popped.data));
                        check("res_ch", 32'(res_ch), 32'(popped.ch));
                    end
                end
                if (prev_valid && !prev_ready) begin
                    check("hold_valid", 32'(res_valid), 32'(1));
                    check("hold_data", 32'(res_data), 32'(prev_data));
                    check("hold_ch", 32'(res_ch), 32'(prev_ch));
                    check("hold_busy", 32'(busy), 32'(1));
                end
                if (prev_valid && prev_ready) begin
                    check("valid_cleared", 32'(res_valid), 32'(0));
                    check("idle_after_handshake", 32'(busy), 32'(0));
                end
            end
            prev_req   = ch_req;
            prev_busy  = busy;
            prev_valid = res_valid;
            prev_ready = res_ready;
            prev_start = adc_start;
            prev_data  = res_data;
            prev_ch    = res_ch;
            prev_sel   = adc_sel;
            prev_rst   = rst;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (adc_start) ok = 1'b1;
        end
        check("wait_start_timeout", 32'(ok), 32'(1));
    endtask

    task automatic wait_valid(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (res_valid) ok = 1'b1;
        end
        check("wait_valid_timeout", 32'(ok), 32'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ch_ack"}, 32'(ch_ack), 32'(0));
        check({tag, "_adc_start"}, 32'(adc_start), 32'(0));
        check({tag, "_adc_sel"}, 32'(adc_sel), 32'(0));
        check({tag, "_res_valid"}, 32'(res_valid), 32'(0));
        check({tag, "_res_data"}, 32'(res_data), 32'(0));
        check({tag, "_res_ch"}, 32'(res_ch), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int rr_order [6] = '{0, 1, 2, 3, 0, 1};
    int last_start;
    int t_start;
    logic [NUM_CH-1:0] rq;

    initial begin
        ch_req    = '0;
        res_ready = 1'b1;
        rst       = 1'b0;
        #1 rst    = 1'b1;
        #1 check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Round-robin with every channel requesting
        ch_req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_start(40);
            check("rr_order", 32'(ch_ack), 32'(1) << rr_order[k]);
            if (k > 0) check("rr_period", 32'(cyc - last_start), 32'(PERIOD));
            last_start = cyc;
        end
        ch_req = '0;
        wait_valid(40);

        // Single request on channel 2
        tick();
        ch_req = 4'b0100;
        wait_start(40);
        check("single_ack", 32'(ch_ack), 32'(4'b0100));
        t_start = cyc;
        ch_req  = '0;
        wait_valid(40);
        check("single_latency", 32'(cyc - t_start), 32'(LATENCY));
        check("single_res_ch", 32'(res_ch), 32'(2));
        tick();
        check("single_busy_fall", 32'(busy), 32'(0));

        // Backpressure with channels 0 and 1 requesting
        ch_req    = 4'b0011;
        res_ready = 1'b0;
        wait_start(40);
        check("bp_first_ack", 32'(ch_ack), 32'(4'b0001));
        wait_valid(40);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_no_start", 32'(adc_start), 32'(0));
        end
        res_ready = 1'b1;
        wait_start(40);
        check("bp_next_ack", 32'(ch_ack), 32'(4'b0010));
        ch_req = '0;
        wait_valid(40);

        // Channel 2 withdraws its request right after being acknowledged
        ch_req = 4'b0100;
        wait_start(40);
        tick();
        ch_req = '0;
        wait_valid(40);
        check("withdraw_res_ch", 32'(res_ch), 32'(2));
        ch_req = 4'b1011;
        wait_start(40);
        check("withdraw_next_ack", 32'(ch_ack), 32'(4'b1000));
        ch_req = '0;

        // Abort the channel 3 conversion with an asynchronous reset
        repeat (4) tick();
        #1 rst = 1'b1;
        #1 check_reset_outputs("abort");
        ch_req = 4'b1010;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_start(40);
        check("abort_next_ack", 32'(ch_ack), 32'(4'b0010));
        ch_req = '0;

        // Randomized requesters and consumer
        for (int n = 0; n < 2000; n++) begin
            tick();
            rq = ch_req;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_ack[c]) begin
                    if ($urandom_range(1, 0) == 0) rq[c] = 1'b0;
                end else if (!rq[c] && $urandom_range(7, 0) == 0) begin
                    rq[c] = 1'b1;
                end
            end
            ch_req    = rq;
            res_ready = ($urandom_range(3, 0) != 0);
        end

        // Drain
        ch_req    = '0;
        res_ready = 1'b1;
        for (int n = 0; n < 60 && (busy || exp_q.size() != 0); n++) tick();
        tick();
        check("drain_busy", 32'(busy), 32'(0));
        check("drain_scoreboard", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
